wm_phase_timer: RTL



---
 rtl/wm_pkg.sv | 24 ++
 rtl/wm_prescaler.sv | 22 ++
 rtl/wm_phase_timer.sv | 71 +++++++
 3 files changed

// File: rtl/wm_pkg.sv
// wm_pkg: washing-machine state encoding and per-phase tick budget lookup shared by controller and timer
package wm_pkg;
  typedef enum logic [2:0] {
    STATE_START,
    STATE_READY,
    STATE_FILL_WATER,
    STATE_HEAT_WATER,
    STATE_WASH,
    STATE_RINSE,
    STATE_SPIN,
    STATE_FAULT
  } wm_state_e;
  function automatic int phase_budget(input logic [2:0] s, input int fill, input int heat,
                                      input int wash, input int rinse, input int spin);
    return s == STATE_FILL_WATER ? fill :
           s == STATE_HEAT_WATER ? heat :
           s == STATE_WASH       ? wash :
           s == STATE_RINSE      ? rinse :
           s == STATE_SPIN       ? spin : 0;
  endfunction
  function automatic logic is_timed(input logic [2:0] s);
    return s >= STATE_FILL_WATER && s <= STATE_SPIN;
  endfunction
endpackage

// File: rtl/wm_prescaler.sv
// wm_prescaler: divides clock into one tick per PRESCALE enabled cycles; clear restarts, enable low freezes
// ports: clock, reset_n (async active-low), clear, enable in; tick out (combinational, gated by enable)
module wm_prescaler #(
  parameter int PRESCALE = 1000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);
  localparam int PW = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  logic [PW-1:0] count_q, count_d;
  always_comb begin
    tick = enable & (count_q == PW'(PRESCALE - 1));
    count_d = clear ? '0 : tick ? '0 : enable ? count_q + PW'(1) : count_q;
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else count_q <= count_d;
  end
endmodule

// File: rtl/wm_phase_timer.sv
// wm_phase_timer: per-phase tick budget timer producing sig_Time_Out (fill/heat) and sig_Completed (wash/rinse/spin)
// ports: clock, reset_n (async active-low), state[2:0], sig_Lid_Closed in;
//        sig_Time_Out, sig_Completed, remaining[CNT_W-1:0], phase_active out
// WM_PAUSE_EN: when defined, an open lid freezes the wash/rinse/spin countdown
module wm_phase_timer
  import wm_pkg::*;
#(
  parameter int PRESCALE    = 1000,
  parameter int CNT_W       = 16,
  parameter int FILL_LIMIT  = 300,
  parameter int HEAT_LIMIT  = 600,
  parameter int WASH_TICKS  = 900,
  parameter int RINSE_TICKS = 400,
  parameter int SPIN_TICKS  = 300
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [2:0]       state,
  input  logic             sig_Lid_Closed,
  output logic             sig_Time_Out,
  output logic             sig_Completed,
  output logic [CNT_W-1:0] remaining,
  output logic             phase_active
);
  localparam longint MAX_B = (longint'(1) << CNT_W) - 1;
  if (PRESCALE < 1 || FILL_LIMIT > MAX_B || HEAT_LIMIT > MAX_B || WASH_TICKS > MAX_B ||
      RINSE_TICKS > MAX_B || SPIN_TICKS > MAX_B) begin : g_param_check
    $error("wm_phase_timer: PRESCALE < 1 or a budget does not fit in CNT_W bits");
  end
  logic [2:0]       latched_state_q, latched_state_d;
  logic [CNT_W-1:0] counter_q, counter_d, budget;
  logic             entry, live, pause, tick, expired, count_en;
  always_comb begin
    entry = state != latched_state_q;
    live = is_timed(state) & ~entry;
    budget = CNT_W'(phase_budget(state, FILL_LIMIT, HEAT_LIMIT, WASH_TICKS, RINSE_TICKS, SPIN_TICKS));
`ifdef WM_PAUSE_EN
    pause = live & (state inside {STATE_WASH, STATE_RINSE, STATE_SPIN}) & ~sig_Lid_Closed;
`else
    pause = 1'b0;
`endif
    count_en = live & (counter_q != '0) & ~pause;
    expired = live & (counter_q == '0);
    latched_state_d = state;
    counter_d = entry ? budget : tick ? counter_q - CNT_W'(1) : counter_q;
    sig_Time_Out = expired & (state == STATE_FILL_WATER || state == STATE_HEAT_WATER);
    sig_Completed = expired & (state inside {STATE_WASH, STATE_RINSE, STATE_SPIN});
    remaining = live ? counter_q : '0;
    phase_active = count_en;
  end
`ifndef WM_PAUSE_EN
  logic unused_lid;
  assign unused_lid = sig_Lid_Closed;
`endif
  wm_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (entry),
    .enable (count_en),
    .tick   (tick)
  );
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      latched_state_q <= '0;
      counter_q <= '0;
    end else begin
      latched_state_q <= latched_state_d;
      counter_q <= counter_d;
    end
  end
endmodule
